// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, round-constant seed,
// the GF(2^8) xtime helper and the AES-128 round count.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam int unsigned AES128_NR = 10;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: start handshake, load strobe, one round strobe per
// round (with index, Rcon, MixColumns enable), then a held done handshake.
// Every output is decoded from registered state only, so nothing an input
// does can reach an output within the same cycle.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR  = AES128_NR,
  parameter int unsigned CPR = 1
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_start_valid,
  output logic       o_start_ready,
  input  logic       i_abort,
  output logic       o_load,
  output logic       o_round_en,
  output logic [3:0] o_round_idx,
  output logic [7:0] o_rcon,
  output logic       o_mix_en,
  output logic       o_final,
  output logic       o_done_valid,
  input  logic       i_done_ready,
  output logic       o_busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [3:0] LAST_SUB   = 4'(CPR - 1);

  state_e     r_state;
  logic [3:0] r_round;
  logic [3:0] r_sub_cnt;
  logic [7:0] r_rcon;

  wire w_in_round   = (r_state == ST_ROUND);
  wire w_sub_last   = (r_sub_cnt == LAST_SUB);
  wire w_round_last = (r_round == LAST_ROUND);

  // Sequencer: state, round counter, sub-cycle counter and round constant.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_round   <= 4'd0;
      r_sub_cnt <= 4'd0;
      r_rcon    <= RCON_INIT;
    end else if (i_abort) begin
      // Abort outranks start and done-ready; any partial block is dropped.
      r_state   <= ST_IDLE;
      r_round   <= 4'd0;
      r_sub_cnt <= 4'd0;
      r_rcon    <= RCON_INIT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start_valid) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_round   <= 4'd1;
          r_sub_cnt <= 4'd0;
          r_rcon    <= RCON_INIT;
          r_state   <= ST_ROUND;
        end
        ST_ROUND: begin
          if (w_sub_last) begin
            if (w_round_last) begin
              r_state <= ST_DONE;
            end else begin
              r_round   <= r_round + 4'd1;
              r_sub_cnt <= 4'd0;
              r_rcon    <= xtime(r_rcon);
            end
          end else begin
            r_sub_cnt <= r_sub_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          if (i_done_ready) begin
            r_state   <= ST_IDLE;
            r_round   <= 4'd0;
            r_sub_cnt <= 4'd0;
            r_rcon    <= RCON_INIT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output decode from registered state; round fields read zero outside ROUND.
  assign o_start_ready = (r_state == ST_IDLE);
  assign o_load        = (r_state == ST_LOAD);
  assign o_round_en    = w_in_round && w_sub_last;
  assign o_round_idx   = w_in_round ? r_round : 4'd0;
  assign o_rcon        = w_in_round ? r_rcon : 8'h00;
  assign o_mix_en      = w_in_round && !w_round_last;
  assign o_final       = w_in_round && w_round_last;
  assign o_done_valid  = (r_state == ST_DONE);
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: one instance with NR=10/CPR=1 and one
// with NR=10/CPR=3. Outputs are sampled 1 time unit after each rising edge.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b0;
  logic start3 = 1'b0, abort3 = 1'b0, ready3 = 1'b0;

  logic       sr1, ld1, re1, mix1, fin1, dv1, busy1;
  logic [3:0] idx1;
  logic [7:0] rcon1;
  logic       sr3, ld3, re3, mix3, fin3, dv3, busy3;
  logic [3:0] idx3;
  logic [7:0] rcon3;

  aes_round_ctrl #(.NR(10), .CPR(1)) dut1 (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_start_valid(start1), .o_start_ready(sr1), .i_abort(abort1),
    .o_load(ld1), .o_round_en(re1), .o_round_idx(idx1), .o_rcon(rcon1),
    .o_mix_en(mix1), .o_final(fin1), .o_done_valid(dv1),
    .i_done_ready(ready1), .o_busy(busy1)
  );

  aes_round_ctrl #(.NR(10), .CPR(3)) dut3 (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_start_valid(start3), .o_start_ready(sr3), .i_abort(abort3),
    .o_load(ld3), .o_round_en(re3), .o_round_idx(idx3), .o_rcon(rcon3),
    .o_mix_en(mix3), .o_final(fin3), .o_done_valid(dv3),
    .i_done_ready(ready3), .o_busy(busy3)
  );

  wire [18:0] obs1 = {sr1, ld1, re1, idx1, rcon1, mix1, fin1, dv1, busy1};
  wire [18:0] obs3 = {sr3, ld3, re3, idx3, rcon3, mix3, fin3, dv3, busy3};

  int total = 0;
  int bad   = 0;

  // Hand-entered round constants for rounds 1..14.
  logic [7:0] rc [1:14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                            8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

  function automatic logic [18:0] pv(input logic sr, input logic ld,
                                     input logic re, input logic [3:0] idx,
                                     input logic [7:0] rcon, input logic mix,
                                     input logic fin, input logic dv,
                                     input logic busy);
    return {sr, ld, re, idx, rcon, mix, fin, dv, busy};
  endfunction

  localparam logic [18:0] IDLE_V = {1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [18:0] LOAD_V = {1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [18:0] DONE_V = {1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};

  // Expected vector for round k of a 10-round run.
  function automatic logic [18:0] rv(input int k, input logic re);
    return pv(1'b0, 1'b0, re, 4'(k), rc[k], (k != 10), (k == 10), 1'b0, 1'b1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state for both instances.
    #2;
    chk("rst1", obs1, IDLE_V);
    chk("rst3", obs3, IDLE_V);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic run NR=10, CPR=1 with done backpressure.
    chk("t1_idle", obs1, IDLE_V);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("t1_load", obs1, LOAD_V);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("t1_rnd%0d", k), obs1, rv(k, 1'b1));
    end
    step();
    chk("t1_done0", obs1, DONE_V);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("t1_hold%0d", i), obs1, DONE_V);
    end
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    chk("t1_back_idle", obs1, IDLE_V);

    // Abort beats start in IDLE, then abort during round 4.
    start1 = 1'b1;
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    chk("ab_prio_idle", obs1, IDLE_V);
    step();
    start1 = 1'b0;
    chk("ab_load", obs1, LOAD_V);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("ab_rnd%0d", k), obs1, rv(k, 1'b1));
    end
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    chk("ab_idle", obs1, IDLE_V);
    step();
    chk("ab_idle2", obs1, IDLE_V);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("ab_reload", obs1, LOAD_V);
    step();
    chk("ab_restart_rnd1", obs1, rv(1, 1'b1));
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    chk("ab_clear", obs1, IDLE_V);

    // Start and done-ready held high through a whole run.
    start1 = 1'b1;
    ready1 = 1'b1;
    step();
    chk("sh_load", obs1, LOAD_V);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("sh_rnd%0d", k), obs1, rv(k, 1'b1));
    end
    step();
    chk("sh_done", obs1, DONE_V);
    step();
    chk("sh_idle", obs1, IDLE_V);
    step();
    chk("sh_load2", obs1, LOAD_V);
    start1 = 1'b0;
    ready1 = 1'b0;
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    chk("sh_clear", obs1, IDLE_V);

    // Asynchronous reset during round 6, then a clean full run.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("rs_load", obs1, LOAD_V);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("rs_rnd%0d", k), obs1, rv(k, 1'b1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async", obs1, IDLE_V);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rs_idle", obs1, IDLE_V);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("rs_reload", obs1, LOAD_V);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("rs_clean_rnd%0d", k), obs1, rv(k, 1'b1));
    end
    step();
    chk("rs_done", obs1, DONE_V);
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    chk("rs_end_idle", obs1, IDLE_V);

    // Multi-cycle rounds: CPR=3, done expected at T+32.
    chk("c3_idle", obs3, IDLE_V);
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    chk("c3_load", obs3, LOAD_V);
    for (int k = 1; k <= 10; k++) begin
      for (int s = 0; s < 3; s++) begin
        step();
        chk($sformatf("c3_rnd%0d_sub%0d", k, s), obs3, rv(k, (s == 2)));
      end
    end
    step();
    chk("c3_done", obs3, DONE_V);
    ready3 = 1'b1;
    step();
    ready3 = 1'b0;
    chk("c3_end_idle", obs3, IDLE_V);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
